// File: rtl/psum_collector_pkg.sv
// Shared constants for the psum collector.
//   COL     : default number of array columns collected
//   PSUM_BW : default width of one column partial sum
//   DEPTH   : default entries per column queue (power of two, >= 2)
//   PTR_W   : queue pointer width for DEPTH, including the wrap bit
package psum_collector_pkg;

  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int DEPTH   = 16;

  // Pointer width for a queue of d entries: index bits plus one wrap bit.
  function automatic int ptr_w(input int d);
    return $clog2(d) + 1;
  endfunction

  localparam int PTR_W = ptr_w(DEPTH);

endpackage

// File: rtl/psum_collector_if.sv
// Bus between the systolic array's bottom row / consumer and the collector.
//   in      : one psum per column, column i at [psum_bw*(i+1)-1 : psum_bw*i]
//   wr      : per-column write strobe (the array's valid bus)
//   rd      : consumer request to pop one full row
//   out     : last popped row, same packing as in
//   o_valid : out holds a row popped on the previous edge
//   o_ready : every column queue holds at least one entry
//   o_full  : at least one column queue is full
//   o_ovf   : sticky, a write was dropped on a full column
//
// Handshake: a row transfer happens on a rising edge where rd=1 and
// o_ready=1. rd without o_ready is simply ignored; the consumer may hold
// rd high continuously. o_ready never depends on rd in the same cycle.
interface psum_collector_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16
);
  logic [psum_bw*col-1:0] in;
  logic [col-1:0]         wr;
  logic                   rd;
  logic [psum_bw*col-1:0] out;
  logic                   o_valid;
  logic                   o_ready;
  logic                   o_full;
  logic                   o_ovf;

  modport master (
    output in, wr, rd,
    input  out, o_valid, o_ready, o_full, o_ovf
  );

  modport slave (
    input  in, wr, rd,
    output out, o_valid, o_ready, o_full, o_ovf
  );
endinterface

// File: rtl/psum_collector_column_fifo.sv
// Single-column circular queue.
//   clk, reset : clock, asynchronous active-high reset (pointers, ovf)
//   push, din  : write request and data
//   pop        : advance read pointer (caller guarantees not empty)
//   dout       : head entry, combinational
//   empty/full : derived from pointers, pre-edge state
//   ovf        : sticky, set when a push hits a full queue with no pop
module column_fifo
  import psum_collector_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [psum_bw-1:0] din,
  output logic [psum_bw-1:0] dout,
  output logic               empty,
  output logic               full,
  output logic               ovf
);

  localparam int PW = ptr_w(depth);
  localparam int AW = PW - 1;

  logic [psum_bw-1:0] mem [depth];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               ovf_q;
  logic               push_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A full queue still takes the write when a slot frees on the same edge.
  assign push_ok = push && (!full || pop);

  assign dout = mem[rd_ptr[AW-1:0]];
  assign ovf  = ovf_q;

  // Storage is not reset: with all pointers cleared it is never read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

endmodule

// File: rtl/psum_collector.sv
// Collects skewed per-column psums from the array's bottom row into one
// queue per column and hands them out as aligned rows.
//   clk   : single clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : psum_collector_if slave (in/wr/rd in, out/o_* out)
module psum_collector
  import psum_collector_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  psum_collector_if.slave   bus
);

  logic [col-1:0]         empty_v;
  logic [col-1:0]         full_v;
  logic [col-1:0]         ovf_v;
  logic [psum_bw*col-1:0] head_row;
  logic                   ready;
  logic                   pop;
  logic [psum_bw*col-1:0] out_q;
  logic                   valid_q;

  // Skew between columns is absorbed by queue order alone: row k is the
  // k-th entry of every column, whenever each one arrived.
  assign ready = ~|empty_v;
  assign pop   = bus.rd && ready;

  for (genvar i = 0; i < col; i++) begin : g_col
    column_fifo #(
      .psum_bw (psum_bw),
      .depth   (depth)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (bus.wr[i]),
      .pop   (pop),
      .din   (bus.in[psum_bw*i +: psum_bw]),
      .dout  (head_row[psum_bw*i +: psum_bw]),
      .empty (empty_v[i]),
      .full  (full_v[i]),
      .ovf   (ovf_v[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= pop;
      if (pop) out_q <= head_row;
    end
  end

  assign bus.out     = out_q;
  assign bus.o_valid = valid_q;
  assign bus.o_ready = ready;
  assign bus.o_full  = |full_v;
  assign bus.o_ovf   = |ovf_v;

endmodule

// File: tb/tb_psum_collector.sv
// Self-checking bench for psum_collector: directed scenarios plus a random
// phase, checked against a queue-per-column reference model.
module tb_psum_collector;
  import psum_collector_pkg::*;

  localparam int W = PSUM_BW * COL;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  psum_collector_if #(.col(COL), .psum_bw(PSUM_BW)) bus ();

  psum_collector #(.col(COL), .psum_bw(PSUM_BW), .depth(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: one plain queue per column
  logic [PSUM_BW-1:0] mq [COL][$];
  logic [W-1:0]       m_out;
  logic               m_valid;
  logic               m_ovf;

  function automatic logic m_ready();
    for (int i = 0; i < COL; i++) if (mq[i].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_full();
    for (int i = 0; i < COL; i++) if (mq[i].size() == DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < COL; i++) mq[i].delete();
    m_out   = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
  endfunction

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    for (int i = 0; i < COL; i++) r[i*PSUM_BW +: PSUM_BW] = PSUM_BW'($urandom);
    return r;
  endfunction

  // checkers
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // driver: one clock cycle of stimulus, model update and checks
  task automatic step(input logic [COL-1:0] w, input logic [W-1:0] d, input logic r);
    logic         pop;
    logic [W-1:0] row;
    int           pre_sz [COL];
    @(negedge clk);
    bus.wr = w;
    bus.in = d;
    bus.rd = r;
    #1;
    chk1("o_ready", bus.o_ready, m_ready());
    chk1("o_full", bus.o_full, m_full());
    pop = r && m_ready();
    row = '0;
    for (int i = 0; i < COL; i++) pre_sz[i] = mq[i].size();
    if (pop) for (int i = 0; i < COL; i++) row[i*PSUM_BW +: PSUM_BW] = mq[i].pop_front();
    for (int i = 0; i < COL; i++) begin
      if (w[i]) begin
        if (pre_sz[i] < DEPTH || pop) mq[i].push_back(d[i*PSUM_BW +: PSUM_BW]);
        else m_ovf = 1'b1;
      end
    end
    m_valid = pop;
    if (pop) m_out = row;
    @(posedge clk);
    #1;
    chk1("o_valid", bus.o_valid, m_valid);
    chk("out", bus.out, m_out);
    chk1("o_ovf", bus.o_ovf, m_ovf);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    m_clear();
    #1;
    chk1("rst_o_ready", bus.o_ready, 1'b0);
    chk1("rst_o_valid", bus.o_valid, 1'b0);
    chk("rst_out", bus.out, '0);
    chk1("rst_o_ovf", bus.o_ovf, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [W-1:0] seq_row;

  initial begin
    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    bus.wr = '0;
    bus.in = '0;
    bus.rd = 1'b0;
    m_clear();
    #1;
    chk1("init_o_ready", bus.o_ready, 1'b0);
    chk1("init_o_valid", bus.o_valid, 1'b0);
    chk("init_out", bus.out, '0);
    chk1("init_o_ovf", bus.o_ovf, 1'b0);
    chk1("init_o_full", bus.o_full, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // aligned write, column i = i+1, then pop
    for (int i = 0; i < COL; i++) seq_row[i*PSUM_BW +: PSUM_BW] = PSUM_BW'(i + 1);
    step('1, seq_row, 1'b0);
    step('0, '0, 1'b1);
    chk1("aligned_valid", bus.o_valid, 1'b1);
    chk("aligned_row", bus.out, seq_row);
    step('0, '0, 1'b0);

    // skewed arrival: column i written at cycle i
    seq_row = rand_row();
    for (int i = 0; i < COL; i++) step(COL'(1) << i, seq_row, 1'b0);
    chk1("skew_ready", bus.o_ready, 1'b1);
    step('0, '0, 1'b1);
    chk("skew_row", bus.out, seq_row);

    // fill, overflow, drain
    for (int i = 0; i < DEPTH; i++) step('1, rand_row(), 1'b0);
    chk1("fill_full", bus.o_full, 1'b1);
    step('1, rand_row(), 1'b0);
    chk1("fill_ovf", bus.o_ovf, 1'b1);
    for (int i = 0; i < DEPTH; i++) step('0, '0, 1'b1);
    step('0, '0, 1'b1);

    // reset during traffic: 5 written, 2 popped, reset between edges
    for (int i = 0; i < 5; i++) step('1, rand_row(), 1'b0);
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);
    @(negedge clk);
    bus.rd = 1'b1;
    #2;
    reset = 1'b1;
    m_clear();
    #1;
    chk1("mid_rst_o_ready", bus.o_ready, 1'b0);
    chk1("mid_rst_o_valid", bus.o_valid, 1'b0);
    chk("mid_rst_out", bus.out, '0);
    chk1("mid_rst_o_ovf", bus.o_ovf, 1'b0);
    @(posedge clk);
    #1;
    chk1("rst_cycle_pop", bus.o_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step('0, '0, 1'b1);
    chk1("post_rst_rd_ignored", bus.o_valid, 1'b0);

    // full queues with write and pop on the same edge
    for (int i = 0; i < DEPTH; i++) step('1, rand_row(), 1'b0);
    seq_row = rand_row();
    step('1, seq_row, 1'b1);
    chk1("wp_full_ovf", bus.o_ovf, 1'b0);
    chk1("wp_full_full", bus.o_full, 1'b1);
    for (int i = 0; i < DEPTH; i++) step('0, '0, 1'b1);
    chk("wp_new_row", bus.out, seq_row);
    step('0, '0, 1'b1);

    // wrap-around: 40 rows of concurrent write/pop
    step('1, rand_row(), 1'b0);
    for (int i = 0; i < 40; i++) step('1, rand_row(), 1'b1);
    step('0, '0, 1'b1);
    chk1("wrap_ovf", bus.o_ovf, 1'b0);

    // random traffic, including skew and overflow
    for (int i = 0; i < 400; i++)
      step(COL'($urandom), rand_row(), ($urandom_range(0, 3) == 0));
    for (int i = 0; i < DEPTH + 2; i++) step('0, '0, 1'b1);

    // reset clears sticky overflow left by the random phase
    do_reset();
    step('0, '0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psum_collector.md
PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 Parameter col, default 8, number of array columns collected.
REQ-002 Parameter psum_bw, default 16, width of one column psum.
REQ-003 Parameter depth, default 16, entries per column queue; power of two, >= 2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in  input  psum_bw*col  psums from the bottom array row; column i occupies bits [psum_bw*(i+1)-1 : psum_bw*i].
REQ-007 wr  input  col  per-column write strobe; the array's valid bus.
REQ-008 rd  input  1  pop one full row.
REQ-009 out  output  psum_bw*col  popped row, same column packing as in.
REQ-010 o_valid  output  1  out holds a freshly popped row this cycle.
REQ-011 o_ready  output  1  every column queue holds >= 1 entry.
REQ-012 o_full  output  1  at least one column queue is full.
REQ-013 o_ovf  output  1  sticky overflow flag.

Function
REQ-014 Each column is an independent circular queue of depth entries, psum_bw bits wide.
- Write pointer, read pointer: log2(depth)+1 bits each; the extra bit is the wrap bit.
- Empty: pointers equal. Full: low bits equal, wrap bits differ.
REQ-015 When wr[i]=1 and column i is not full, in[column i] is stored and the column i write pointer advances by 1.
REQ-016 When wr[i]=1 and column i is full, the write is accepted only if a pop occurs in the same cycle.
- Otherwise the data is dropped, that pointer is unchanged, and o_ovf is set to 1.
REQ-017 Columns write independently; skewed valid arrival across columns is normal and is aligned purely by queue order.
REQ-018 o_ready is combinational: the AND over all columns of not-empty.
REQ-019 A pop occurs when rd=1 and o_ready=1; all column read pointers advance by 1 together.
REQ-020 rd=1 while o_ready=0 is ignored, with no state change and no error.
REQ-021 On a pop, out is registered with the head entry of every column at the pop edge.
- o_valid is 1 in the following cycle only, giving a read latency of 1 cycle.
- Back-to-back pops give o_valid=1 on consecutive cycles.
REQ-022 When no pop occurs, out holds its last value and o_valid is 0.
REQ-023 A write and a pop on the same column in the same cycle are both performed; occupancy is unchanged.
REQ-024 Pointers wrap modulo 2*depth with no special-casing.
REQ-025 o_full is combinational from the pointers and reflects pre-edge state.
REQ-026 o_ovf stays 1 until reset.

Reset
REQ-027 Reset asserted sets all pointers to 0, out to 0, o_valid to 0 and o_ovf to 0, immediately and independent of clk.
REQ-028 Queue storage is not reset; it is unobservable because every queue is empty.
REQ-029 Reset mid-operation discards all queued data, and any pop issued in the reset cycle produces no o_valid.
REQ-030 The first write is accepted on the first rising edge after reset deasserts.

Structure
REQ-031 A shared package holds the defaults COL=8, PSUM_BW=16 and DEPTH=16, and the pointer width, derived from depth as log2(depth)+1.
REQ-032 One sub-module, column_fifo, implements the single-column queue.
- It exposes push, pop, data in/out, empty, full and overflow.
- psum_collector instantiates col copies and holds the o_ready/pop logic and the out/o_valid registers.

Verification
REQ-033 Aligned write: write wr=8'hFF, with column i data = i+1, then rd=1 -> o_valid=1 next cycle, out columns 1..8.
REQ-034 Skewed arrival:
- Stimulus: wr=8'h01 at cycle 0, with wr[i] asserted at cycle i.
- Response: o_ready is 0 until cycle 8 and 1 from cycle 8; the pop returns every column's first value.
REQ-035 Fill, then overflow:
- Write 16 rows with wr=8'hFF -> o_full=1.
- 17th write with rd=0 -> o_ovf=1, and the 16 subsequent pops return rows 1..16 in order.
REQ-036 Full column with write and pop in the same cycle:
- Stimulus: all columns full; wr=8'hFF and rd=1 in the same cycle.
- Response: o_ovf stays 0, o_full stays 1, and the new row emerges 16 pops later.
REQ-037 Reset during traffic:
- Stimulus: after 5 rows written and 2 popped, assert reset asynchronously between edges.
- Response: o_ready=0, o_valid=0, out=0 and o_ovf=0 immediately; a subsequent rd is ignored.
REQ-038 Wrap-around: sustain 40 rows of concurrent write/pop at depth 16 -> the output sequence matches the input sequence exactly, with o_ovf=0.
